// File: rtl/multi_cycle_adder_if.sv
// Handshake and data bundle between an operand producer, the digit-serial
// adder and the result consumer.
interface multi_cycle_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inp_1;
  logic [WIDTH-1:0] inp_2;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, inp_1, inp_2, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, inp_1, inp_2, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/multi_cycle_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice with a registered carry
// walks the operands LSB digit first, with valid/ready on both sides.
module multi_cycle_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_cycle_adder_if.slave  bus
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [DIGIT:0] add_slice(
    input logic [DIGIT-1:0] a,
    input logic [DIGIT-1:0] b,
    input logic             cin
  );
    add_slice = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  endfunction

  // Same-sign operands producing a different-sign result is equivalent to
  // carry-into-MSB differing from carry-out-of-MSB.
  function automatic logic signed_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    signed_ovf = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] digit_q, digit_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [DIGIT:0]   slice_s;

  // State, operand shift registers, running carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      c_q     <= 1'b0;
      digit_q <= {CNT_W{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      digit_q <= digit_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath: operands shift right so the slice always sees bit 0.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    digit_d = digit_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    slice_s = add_slice(a_q[DIGIT-1:0], b_q[DIGIT-1:0], c_q);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          a_d     = bus.inp_1;
          b_d     = bus.sub ? ~bus.inp_2 : bus.inp_2;
          c_d     = bus.sub;
          digit_d = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d = a_q >> DIGIT;
        b_d = b_q >> DIGIT;
        c_d = slice_s[DIGIT];
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (digit_q == CNT_W'(i)) begin
            sum_d[i*DIGIT +: DIGIT] = slice_s[DIGIT-1:0];
          end else begin
            sum_d[i*DIGIT +: DIGIT] = sum_q[i*DIGIT +: DIGIT];
          end
        end
        if (digit_q == LAST_DIGIT) begin
          state_d = DONE;
          digit_d = {CNT_W{1'b0}};
          carry_d = slice_s[DIGIT];
          ovf_d   = signed_ovf(a_q[DIGIT-1], b_q[DIGIT-1], slice_s[DIGIT-1]);
        end else begin
          state_d = RUN;
          digit_d = digit_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Self-checking bench: a 16/4 and an 8/8 instance checked against an
// arithmetic reference model with directed and random operations.
module tb_multi_cycle_adder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  multi_cycle_adder_if #(.WIDTH(16)) m16 ();
  multi_cycle_adder_if #(.WIDTH(8))  m8 ();

  multi_cycle_adder #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(m16.slave));
  multi_cycle_adder #(.WIDTH(8),  .DIGIT(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(m8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, carry, sum} from plain integer arithmetic.
  function automatic logic [63:0] model(input longint a, input longint b, input logic s, input int w);
    longint m, res, sa, sb, r;
    logic   cy, ov;
    m   = 64'sd1 <<< w;
    res = s ? ((a - b + m) % m) : ((a + b) % m);
    cy  = s ? (a >= b) : ((a + b) >= m);
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    r   = s ? sa - sb : sa + sb;
    ov  = (r >= m / 2) || (r < -(m / 2));
    model = 64'(res) | (64'(cy) << w) | (64'(ov) << (w + 1));
  endfunction

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s, input int bp);
    logic [63:0] e;
    e = model(longint'(a), longint'(b), s, 16);
    @(negedge clk);
    chk("idle_ready16", m16.in_ready, 64'd1);
    m16.in_valid = 1'b1; m16.inp_1 = a; m16.inp_2 = b; m16.sub = s;
    @(negedge clk);
    chk("run_ready16", m16.in_ready, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      m16.in_valid = 1'($urandom); m16.inp_1 = 16'($urandom); m16.inp_2 = 16'($urandom); m16.sub = 1'($urandom);
      @(negedge clk);
      if (i < 4) begin
        chk("early_valid16", m16.out_valid, 64'd0);
        chk("busy_ready16", m16.in_ready, 64'd0);
      end else begin
        chk("latency_valid16", m16.out_valid, 64'd1);
      end
    end
    chk("sum16", m16.sum, 64'(e[15:0]));
    chk("carry16", m16.carry, 64'(e[16]));
    chk("ovf16", m16.overflow, 64'(e[17]));
    for (int i = 0; i < bp; i++) begin
      m16.in_valid = 1'($urandom); m16.inp_1 = 16'($urandom); m16.inp_2 = 16'($urandom); m16.sub = 1'($urandom);
      @(negedge clk);
      chk("bp_valid16", m16.out_valid, 64'd1);
      chk("bp_ready16", m16.in_ready, 64'd0);
      chk("bp_hold16", {m16.overflow, m16.carry, m16.sum}, 64'(e[17:0]));
    end
    m16.in_valid = 1'b0; m16.out_ready = 1'b1;
    @(negedge clk);
    m16.out_ready = 1'b0;
    chk("drain_valid16", m16.out_valid, 64'd0);
    chk("drain_ready16", m16.in_ready, 64'd1);
    chk("drain_hold16", {m16.overflow, m16.carry, m16.sum}, 64'(e[17:0]));
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [63:0] e;
    e = model(longint'(a), longint'(b), s, 8);
    @(negedge clk);
    chk("idle_ready8", m8.in_ready, 64'd1);
    m8.in_valid = 1'b1; m8.inp_1 = a; m8.inp_2 = b; m8.sub = s;
    @(negedge clk);
    m8.in_valid = 1'b0;
    chk("run_valid8", m8.out_valid, 64'd0);
    chk("run_ready8", m8.in_ready, 64'd0);
    @(negedge clk);
    chk("latency_valid8", m8.out_valid, 64'd1);
    chk("result8", {m8.overflow, m8.carry, m8.sum}, 64'(e[9:0]));
    m8.out_ready = 1'b1;
    @(negedge clk);
    m8.out_ready = 1'b0;
    chk("drain_valid8", m8.out_valid, 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    m16.in_valid = 1'b0; m16.inp_1 = 16'd0; m16.inp_2 = 16'd0; m16.sub = 1'b0; m16.out_ready = 1'b0;
    m8.in_valid  = 1'b0; m8.inp_1  = 8'd0;  m8.inp_2  = 8'd0;  m8.sub  = 1'b0; m8.out_ready  = 1'b0;
    #1;
    chk("rst_ready", m16.in_ready, 64'd1);
    chk("rst_valid", m16.out_valid, 64'd0);
    chk("rst_outs", {m16.overflow, m16.carry, m16.sum}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run16(16'h1234, 16'h1111, 1'b0, 0);
    run16(16'hFFFF, 16'h0001, 1'b0, 0);
    run16(16'h7FFF, 16'h0001, 1'b0, 1);
    run16(16'h0005, 16'h0007, 1'b1, 0);
    run16(16'h8000, 16'h0001, 1'b1, 5);
    run16(16'h0000, 16'h0000, 1'b1, 0);

    // Reset after the third digit has been written.
    @(negedge clk);
    m16.in_valid = 1'b1; m16.inp_1 = 16'hABCD; m16.inp_2 = 16'h1357; m16.sub = 1'b0;
    @(negedge clk);
    m16.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", m16.in_ready, 64'd1);
    chk("mid_rst_valid", m16.out_valid, 64'd0);
    chk("mid_rst_sum", m16.sum, 64'd0);
    m16.in_valid = 1'b1;
    @(negedge clk);
    m16.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_ready", m16.in_ready, 64'd1);
    chk("post_rst_valid", m16.out_valid, 64'd0);
    run16(16'h0001, 16'h0001, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    run8(8'h80, 8'h80, 1'b0);
    run8(8'h7F, 8'h01, 1'b0);
    run8(8'h00, 8'h01, 1'b1);
    for (int k = 0; k < 10; k++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
